// File: rtl/lsu_data_if.sv
// Load/store unit between the execute stage and the single-port data RAM.
// Word-aligned req/gnt/rvalid handshake, lane steering and load extension.
module lsu_data_if #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [2:0]            lsu_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [31:0]           lsu_wdata,
    output logic [31:0]           lsu_rdata,
    output logic                  lsu_done,
    output logic                  lsu_stall,
    output logic                  lsu_misaligned,
    output logic                  data_req,
    input  logic                  data_gnt,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  data_we,
    output logic [3:0]            data_be,
    output logic [31:0]           data_wdata,
    input  logic                  data_rvalid,
    input  logic [31:0]           data_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            f3_q, f3_d;

    logic [1:0]            off;
    logic                  bad;
    logic [3:0]            be_c;
    logic [31:0]           wd_c;
    logic [31:0]           sh;
    logic [31:0]           ext;

    assign off = lsu_addr[1:0];

    // Decode request size into lane mask, replicated store data and legality
    always_comb begin
        be_c = 4'b0000;
        wd_c = 32'h0;
        bad  = 1'b1;
        unique case (lsu_funct3[1:0])
            2'b00: begin
                be_c = 4'b0001 << off;
                wd_c = {4{lsu_wdata[7:0]}};
                bad  = lsu_we & lsu_funct3[2];
            end
            2'b01: begin
                be_c = 4'b0011 << off;
                wd_c = {2{lsu_wdata[15:0]}};
                bad  = off[0] | (lsu_we & lsu_funct3[2]);
            end
            2'b10: begin
                be_c = 4'b1111;
                wd_c = lsu_wdata;
                bad  = (off != 2'b00) | lsu_funct3[2];
            end
            default: begin
                be_c = 4'b0000;
                wd_c = 32'h0;
                bad  = 1'b1;
            end
        endcase
    end

    assign sh = data_rdata >> {off_q, 3'b000};

    // Extend the addressed lane of the returned word
    always_comb begin
        ext = sh;
        unique case (f3_q)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ext = {24'h0, sh[7:0]};
            3'b101:  ext = {16'h0, sh[15:0]};
            default: ext = sh;
        endcase
    end

    // Next-state and captured-access logic
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        off_d   = off_q;
        f3_d    = f3_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_req) begin
                    rdata_d = 32'h0;
                    if (bad) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mis_d   = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                        we_d    = lsu_we;
                        be_d    = be_c;
                        wdata_d = wd_c;
                        off_d   = off;
                        f3_d    = lsu_funct3;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (data_gnt) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid) begin
                    if (!we_q) begin
                        rdata_d = ext;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured access registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
        end
    end

    assign lsu_done       = (state_q == DONE);
    assign lsu_misaligned = lsu_done & mis_q;
    assign lsu_stall      = lsu_req & ~lsu_done;
    assign lsu_rdata      = rdata_q;
    assign data_req       = req_q;
    assign data_addr      = addr_q;
    assign data_we        = we_q;
    assign data_be        = be_q;
    assign data_wdata     = wdata_q;

endmodule
